// File: rtl/spike_rate_decoder.sv
// Spike-count rate decoder: counts spikes over WINDOW cycles and presents a saturated
// count on a valid/ready port. Define RATE_SMOOTH_EN for a rounded two-point running average.
module spike_rate_decoder #(
    parameter int WINDOW = 255,
    parameter int OUT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             spike,
    output logic [OUT_W-1:0] rate,
    output logic             rate_valid,
    input  logic             rate_ready,
    output logic             overrun,
    output logic             busy
);

    localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int CW = $clog2(WINDOW + 1);
    localparam int SW = (CW > OUT_W + 1) ? CW : OUT_W + 1;
    localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);
    localparam logic [SW-1:0] RATE_MAX = SW'((2 ** OUT_W) - 1);

    typedef enum logic {S_IDLE, S_COUNT} state_t;

    state_t           r_state, w_state_next;
    logic [WW-1:0]    r_win_cnt, w_win_cnt_next;
    logic [CW-1:0]    r_spk_cnt, w_spk_cnt_next;
    logic [OUT_W-1:0] r_rate, w_rate_next;
    logic             r_rate_valid, w_rate_valid_next;
    logic             r_overrun, w_overrun_next;

    logic             w_close;
    logic             w_xfer;
    logic [SW-1:0]    w_count;
    logic [OUT_W-1:0] w_sat;
    logic [OUT_W-1:0] w_load;

    assign w_close = (r_state == S_COUNT) && (r_win_cnt == WIN_LAST);
    assign w_xfer  = r_rate_valid && rate_ready;
    // The closing cycle's spike belongs to the window it closes.
    assign w_count = SW'(r_spk_cnt) + SW'(spike);
    assign w_sat   = (w_count > RATE_MAX) ? {OUT_W{1'b1}} : w_count[OUT_W-1:0];

`ifdef RATE_SMOOTH_EN
    logic             r_first;
    logic [OUT_W:0]   w_avg;

    assign w_avg  = ({1'b0, r_rate} + {1'b0, w_sat} + (OUT_W + 1)'(1)) >> 1;
    assign w_load = r_first ? w_sat : w_avg[OUT_W-1:0];

    // Only reset re-arms the direct load; enable toggling keeps the running average.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_first <= 1'b1;
        end else if (w_close) begin
            r_first <= 1'b0;
        end
    end
`else
    assign w_load = w_sat;
`endif

    always_comb begin
        w_state_next      = r_state;
        w_win_cnt_next    = r_win_cnt;
        w_spk_cnt_next    = r_spk_cnt;
        w_rate_next       = r_rate;
        w_rate_valid_next = r_rate_valid;
        w_overrun_next    = r_overrun;

        if (w_xfer) begin
            w_rate_valid_next = 1'b0;
        end

        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_next = S_COUNT;
                end
            end
            S_COUNT: begin
                if (w_close) begin
                    w_rate_next       = w_load;
                    w_rate_valid_next = 1'b1;
                    if (r_rate_valid && !rate_ready) begin
                        w_overrun_next = 1'b1;
                    end
                    w_win_cnt_next = '0;
                    w_spk_cnt_next = '0;
                end else begin
                    w_win_cnt_next = r_win_cnt + WW'(1);
                    w_spk_cnt_next = r_spk_cnt + CW'(spike);
                end
                // A closing window still completes when enable drops on the same edge.
                if (!enable) begin
                    w_state_next   = S_IDLE;
                    w_win_cnt_next = '0;
                    w_spk_cnt_next = '0;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state      <= S_IDLE;
            r_win_cnt    <= '0;
            r_spk_cnt    <= '0;
            r_rate       <= '0;
            r_rate_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_win_cnt    <= w_win_cnt_next;
            r_spk_cnt    <= w_spk_cnt_next;
            r_rate       <= w_rate_next;
            r_rate_valid <= w_rate_valid_next;
            r_overrun    <= w_overrun_next;
        end
    end

    assign rate       = r_rate;
    assign rate_valid = r_rate_valid;
    assign overrun    = r_overrun;
    assign busy       = (r_state == S_COUNT);

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
- Converts the 1-bit spike train from a neuron back into an 8-bit rate value by counting spikes over a fixed window of cycles. It is the decode-side counterpart of the current-to-spike neuron.
- Sits downstream of a neuron's spike output.
- Presents one count per window on a valid/ready handshake to the readout or next-layer logic.

Parameters:
- WINDOW, 255, window length in clock cycles (legal range 2..65535).
- OUT_W, 8, width of rate output; the count saturates at 2^OUT_W-1.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous, active-high reset (name kept for top-level consistency; asserted = 1)
- enable  input  1  1 = decode windows; 0 = idle, partial window discarded
- spike  input  1  spike sample, one per cycle
- rate  output  OUT_W  spike count of last completed window
- rate_valid  output  1  rate holds an unconsumed result
- rate_ready  input  1  consumer accepts rate when rate_valid & rate_ready
- overrun  output  1  sticky: a result was overwritten before acceptance
- busy  output  1  1 while in COUNT state

Behaviour:
- Reset (async, rst_n=1): state=IDLE, win_cnt=0, spk_cnt=0, rate=0, rate_valid=0, overrun=0, busy=0.
- States: IDLE, COUNT.
  - IDLE -> COUNT on the edge where enable=1; busy=1 from the next cycle.
  - COUNT -> IDLE on any edge with enable=0; win_cnt and spk_cnt are cleared. rate, rate_valid and overrun are untouched.
- In COUNT, spike is sampled every cycle. The first sampled cycle is the first cycle with busy=1.
- win_cnt runs 0..WINDOW-1.
  - On the edge where win_cnt==WINDOW-1: rate <= sat(spk_cnt+spike), rate_valid <= 1, win_cnt <= 0, spk_cnt <= 0.
  - The next window starts with no gap cycle.
- Window-end latency: rate_valid rises on the edge that closes the window, i.e. WINDOW cycles after the first sample.
- Saturation: spk_cnt is internally wide enough for WINDOW. rate = min(count, 2^OUT_W-1); no wrap.
- Handshake:
  - A transfer occurs on an edge with rate_valid=1 and rate_ready=1. rate_valid then clears unless a new window closes on the same edge.
  - rate is stable while rate_valid=1 and no new window closes.
  - rate_ready while rate_valid=0 is ignored.
- Simultaneous window close and transfer: the old value is consumed, the new value is loaded, rate_valid stays 1, and overrun is not set.
- Window close while rate_valid=1 and rate_ready=0: the new value overwrites rate, rate_valid stays 1, and overrun <= 1.
- overrun is cleared only by reset.
- enable dropping on the same edge as the window close: the window completes (result loaded), then the block goes to IDLE.
- Reset mid-window or mid-handshake: all state returns to reset values immediately; no result is produced.

Optional Feature:
- Macro RATE_SMOOTH_EN.
- Defined:
  - The first result after reset loads directly.
  - Each later window close loads rate <= (rate + sat_count + 1) >> 1, a rounded two-point running average computed in OUT_W+1 bits.
  - The result still sets rate_valid and overrun exactly as above.
  - A "first" flag is cleared by reset only; it is not cleared by enable.
- Not defined: rate = sat_count as specified, with no smoothing logic present.

Test Plan:
- Reset then enable=1, spike held 0 for 255 cycles -> rate_valid=1 with rate=0 on the closing edge; busy=1 throughout.
- WINDOW=255, spike=1 every cycle, rate_ready=1 -> each window yields rate=255. rate_valid pulses one cycle every 255 cycles with no dropped window; overrun=0.
- WINDOW=16, OUT_W=3, spike=1 every cycle -> rate saturates at 7, with no wrap.
- WINDOW=16, spike every 4th cycle, rate_ready=0 for two windows -> first rate=4, then overwritten with 4 and overrun=1. Then rate_ready=1 -> one transfer, rate_valid=0, overrun stays 1.
- enable dropped at win_cnt=8 with 3 spikes counted, then re-raised -> no result for the partial window; the next full window reports only its own spikes. Async reset asserted mid-window -> all outputs 0 immediately.
- RATE_SMOOTH_EN, WINDOW=16, window counts 8 then 4 -> rate=8, then rate=6.
